// File: rtl/stevej_watchdog_escalator.sv
`default_nettype none
// ============================================================================
//  Module   : stevej_watchdog_escalator
//  Purpose  : Turns a window-watchdog expiry level into a staged escalation:
//             interrupt -> programmable grace countdown -> fixed-width system
//             reset pulse -> latched hold until software acknowledges.
//             Exposed as a TinyQV user peripheral with a small register map.
//  Revision : 1.0 - initial release
// ============================================================================
module stevej_watchdog_escalator #(
    parameter int CNT_W   = 16,
    parameter int PULSE_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        expired_in,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt,
    output logic        sys_reset_out,
    output logic [7:0]  uo_out
);

    // ------------------------------------------------------------------------
    // Register map addresses
    // ------------------------------------------------------------------------
    localparam logic [5:0] C_ADDR_CTRL   = 6'h0;
    localparam logic [5:0] C_ADDR_GRACE  = 6'h1;
    localparam logic [5:0] C_ADDR_PULSE  = 6'h2;
    localparam logic [5:0] C_ADDR_ACK    = 6'h3;
    localparam logic [5:0] C_ADDR_STATUS = 6'h4;
    localparam logic [5:0] C_ADDR_EVENTS = 6'h5;

    localparam logic [CNT_W-1:0]   C_G_ONE  = CNT_W'(1);
    localparam logic [PULSE_W-1:0] C_P_ONE  = PULSE_W'(1);
    localparam logic [7:0]         C_EV_MAX = 8'hFF;

    // ------------------------------------------------------------------------
    // Escalation states; the numeric encoding is software visible
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_RESET   = 2'd2,
        ST_HOLD    = 2'd3
    } state_e;

    state_e               state_q,      state_d;
    logic                 enable_q,     enable_d;
    logic                 auto_rearm_q, auto_rearm_d;
    logic [CNT_W-1:0]     grace_q,      grace_d;
    logic [PULSE_W-1:0]   pulse_len_q,  pulse_len_d;
    logic [CNT_W-1:0]     gcnt_q,       gcnt_d;
    logic [PULSE_W-1:0]   pcnt_q,       pcnt_d;
    logic [7:0]           event_q,      event_d;
    logic                 expired_dly_q;

    logic                 w_wr;
    logic                 w_wr_ctrl;
    logic                 w_wr_grace;
    logic                 w_wr_pulse;
    logic                 w_ack;
    logic                 w_wr_events;
    logic                 w_rise;
    logic                 w_run;
    logic                 w_event_inc;
    logic [PULSE_W-1:0]   w_pulse_load;
    logic [1:0]           w_state_bits;
    logic                 w_unused_bits;

    // ------------------------------------------------------------------------
    // Bus decode: any data_write_n other than 2'b11 is a write strobe
    // ------------------------------------------------------------------------
    assign w_wr        = (data_write_n != 2'b11);
    assign w_wr_ctrl   = w_wr && (address == C_ADDR_CTRL);
    assign w_wr_grace  = w_wr && (address == C_ADDR_GRACE);
    assign w_wr_pulse  = w_wr && (address == C_ADDR_PULSE);
    assign w_ack       = w_wr && (address == C_ADDR_ACK);
    assign w_wr_events = w_wr && (address == C_ADDR_EVENTS);

    // Reads are side-effect free, so the read strobe and unused write-data
    // bits are intentionally ignored.
    assign w_unused_bits = ^{data_read_n, data_in};

    assign w_rise       = expired_in & ~expired_dly_q;
    assign w_pulse_load = (pulse_len_q == '0) ? C_P_ONE : pulse_len_q;
    assign w_state_bits = state_q;

    // Clearing enable through CTRL forces the escalation back to IDLE on the
    // very next cycle, so the FSM looks at the enable value being written.
    assign w_run = enable_d;

    // Configuration next-state: CTRL writable always, timing regs only in IDLE
    always_comb begin
        enable_d     = enable_q;
        auto_rearm_d = auto_rearm_q;
        grace_d      = grace_q;
        pulse_len_d  = pulse_len_q;
        if (w_wr_ctrl) begin
            enable_d     = data_in[0];
            auto_rearm_d = data_in[1];
        end
        if (w_wr_grace && (state_q == ST_IDLE)) begin
            grace_d = data_in[CNT_W-1:0];
        end
        if (w_wr_pulse && (state_q == ST_IDLE)) begin
            pulse_len_d = data_in[PULSE_W-1:0];
        end
    end

    // Escalation FSM next-state and counter updates
    always_comb begin
        state_d     = state_q;
        gcnt_d      = gcnt_q;
        pcnt_d      = pcnt_q;
        w_event_inc = 1'b0;
        if (!w_run) begin
            state_d = ST_IDLE;
            gcnt_d  = '0;
            pcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // ACK is meaningless here; only a fresh edge matters
                    if (w_rise) begin
                        state_d     = ST_PENDING;
                        gcnt_d      = grace_q;
                        w_event_inc = 1'b1;
                    end
                end
                ST_PENDING: begin
                    // ACK beats an expiring grace counter in the same cycle
                    if (w_ack) begin
                        state_d = ST_IDLE;
                        gcnt_d  = '0;
                    end else if (gcnt_q == '0) begin
                        state_d = ST_RESET;
                        pcnt_d  = w_pulse_load;
                    end else begin
                        gcnt_d = gcnt_q - C_G_ONE;
                    end
                end
                ST_RESET: begin
                    // The pulse cannot be cut short by ACK; <= guards a zero
                    // count against wrapping.
                    if (pcnt_q <= C_P_ONE) begin
                        state_d = auto_rearm_q ? ST_IDLE : ST_HOLD;
                        pcnt_d  = '0;
                    end else begin
                        pcnt_d = pcnt_q - C_P_ONE;
                    end
                end
                ST_HOLD: begin
                    if (w_ack) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Event counter: a clear write overrides a same-cycle increment
    always_comb begin
        event_d = event_q;
        if (w_wr_events) begin
            event_d = '0;
        end else if (w_event_inc && (event_q != C_EV_MAX)) begin
            event_d = event_q + 8'd1;
        end
    end

    // State, configuration and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            enable_q      <= 1'b0;
            auto_rearm_q  <= 1'b0;
            grace_q       <= '0;
            pulse_len_q   <= '0;
            gcnt_q        <= '0;
            pcnt_q        <= '0;
            event_q       <= '0;
            expired_dly_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            enable_q      <= enable_d;
            auto_rearm_q  <= auto_rearm_d;
            grace_q       <= grace_d;
            pulse_len_q   <= pulse_len_d;
            gcnt_q        <= gcnt_d;
            pcnt_q        <= pcnt_d;
            event_q       <= event_d;
            expired_dly_q <= expired_in;
        end
    end

    // Combinational read mux; unmapped and write-only addresses return 0
    always_comb begin
        data_out = '0;
        case (address)
            C_ADDR_CTRL: begin
                data_out[0] = enable_q;
                data_out[1] = auto_rearm_q;
            end
            C_ADDR_GRACE: begin
                data_out[CNT_W-1:0] = grace_q;
            end
            C_ADDR_PULSE: begin
                data_out[PULSE_W-1:0] = pulse_len_q;
            end
            C_ADDR_STATUS: begin
                data_out = {16'h0, event_q, 3'b000, expired_in, enable_q,
                            auto_rearm_q, w_state_bits};
            end
            C_ADDR_EVENTS: begin
                data_out[7:0] = event_q;
            end
            default: begin
                data_out = '0;
            end
        endcase
    end

    assign data_ready     = 1'b1;
    assign user_interrupt = (state_q == ST_PENDING) || (state_q == ST_HOLD);
    assign sys_reset_out  = (state_q == ST_RESET);
    assign uo_out         = {sys_reset_out, user_interrupt, w_state_bits,
                             expired_in, enable_q, 2'b00};

endmodule
`default_nettype wire

// File: tb/tb_stevej_watchdog_escalator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stevej_watchdog_escalator
//  Purpose  : Scoreboard bench for the watchdog escalator. The driver pushes
//             cycle-stamped expectations; an independent monitor pops and
//             compares them against the DUT outputs on the matching cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stevej_watchdog_escalator;

    localparam int K_UINT = 0;
    localparam int K_SYS  = 1;
    localparam int K_DOUT = 2;
    localparam int K_UO   = 3;
    localparam int K_RDY  = 4;

    typedef struct {
        int          cyc;
        int          kind;
        string       nm;
        logic [31:0] exp;
    } chk_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        expired_in;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;
    logic        sys_reset_out;
    logic [7:0]  uo_out;

    chk_t sb[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    bit   done   = 1'b0;

    stevej_watchdog_escalator #(.CNT_W(16), .PULSE_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .expired_in     (expired_in),
        .address        (address),
        .data_in        (data_in),
        .data_write_n   (data_write_n),
        .data_read_n    (data_read_n),
        .data_out       (data_out),
        .data_ready     (data_ready),
        .user_interrupt (user_interrupt),
        .sys_reset_out  (sys_reset_out),
        .uo_out         (uo_out)
    );

    always #5 clk = ~clk;

    // Cycle stamp shared by driver and monitor
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void exp_at(int dt, int kind, string nm, logic [31:0] v);
        chk_t e;
        e.cyc  = cyc + dt;
        e.kind = kind;
        e.nm   = nm;
        e.exp  = v;
        sb.push_back(e);
    endfunction

    function automatic logic [31:0] observe(int kind);
        case (kind)
            K_UINT:  return {31'd0, user_interrupt};
            K_SYS:   return {31'd0, sys_reset_out};
            K_DOUT:  return data_out;
            K_UO:    return {24'd0, uo_out};
            default: return {31'd0, data_ready};
        endcase
    endfunction

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        address      = a;
        data_in      = d;
        data_write_n = 2'b00;
        @(negedge clk);
        data_write_n = 2'b11;
    endtask

    task automatic rd(input logic [5:0] a, input logic [31:0] e, input string nm);
        address = a;
        exp_at(0, K_DOUT, nm, e);
        @(negedge clk);
    endtask

    // Monitor: compare every expectation stamped for the current cycle
    initial begin
        forever begin
            logic [31:0] obs;
            @(negedge clk);
            #2;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= cyc) begin
                    obs = observe(sb[i].kind);
                    n_cmp++;
                    if (sb[i].cyc < cyc) begin
                        n_bad++;
                        $display("FAIL %s: missed check for cycle %0d (now %0d)",
                                 sb[i].nm, sb[i].cyc, cyc);
                    end else if (obs !== sb[i].exp) begin
                        n_bad++;
                        $display("FAIL %s @cyc %0d: got %h, want %h",
                                 sb[i].nm, cyc, obs, sb[i].exp);
                    end
                    sb.delete(i);
                end
            end
        end
    end

    // Driver: directed scenarios with hand-computed expectations
    initial begin
        rst          = 1'b1;
        expired_in   = 1'b0;
        address      = '0;
        data_in      = '0;
        data_write_n = 2'b11;
        data_read_n  = 2'b11;
        tick(3);

        // Reset state
        exp_at(0, K_UINT, "rst_int", 0);
        exp_at(0, K_SYS,  "rst_sys", 0);
        exp_at(0, K_UO,   "rst_uo",  0);
        exp_at(0, K_RDY,  "rst_rdy", 1);
        rst = 1'b0;
        rd(6'h0, 0, "rst_ctrl");
        rd(6'h1, 0, "rst_grace");
        rd(6'h2, 0, "rst_pulse");
        rd(6'h3, 0, "rst_ack");
        rd(6'h4, 0, "rst_status");
        rd(6'h5, 0, "rst_events");
        rd(6'h3F, 0, "rst_unmapped");

        // Basic escalation: GRACE=3, PULSE_LEN=4
        wr(6'h0, 1);
        wr(6'h1, 3);
        wr(6'h2, 4);
        expired_in = 1'b1;
        exp_at(0, K_UINT, "b_pre_int", 0);
        for (int k = 1; k <= 4; k++) begin
            exp_at(k, K_UINT, "b_pend_int", 1);
            exp_at(k, K_SYS,  "b_pend_sys", 0);
        end
        for (int k = 5; k <= 8; k++) begin
            exp_at(k, K_SYS,  "b_rst_sys", 1);
            exp_at(k, K_UINT, "b_rst_int", 0);
        end
        exp_at(9,  K_SYS,  "b_hold_sys", 0);
        exp_at(9,  K_UINT, "b_hold_int", 1);
        exp_at(9,  K_UO,   "b_hold_uo",  32'h7C);
        exp_at(10, K_UINT, "b_hold_int2", 1);
        tick(11);
        expired_in = 1'b0;
        exp_at(1, K_UINT, "b_ack_int", 0);
        wr(6'h3, 0);
        rd(6'h5, 1, "b_events");

        // Early abort: ACK two cycles into PENDING
        wr(6'h5, 0);
        wr(6'h1, 10);
        expired_in = 1'b1;
        exp_at(1, K_UINT, "a_pend_int", 1);
        exp_at(2, K_UINT, "a_pend_int2", 1);
        exp_at(1, K_SYS,  "a_pend_sys", 0);
        exp_at(2, K_SYS,  "a_pend_sys2", 0);
        tick(2);
        exp_at(1, K_UINT, "a_idle_int", 0);
        wr(6'h3, 0);
        for (int k = 0; k <= 12; k++) exp_at(k, K_SYS, "a_no_rst", 0);
        tick(13);
        expired_in = 1'b0;
        rd(6'h5, 1, "a_events");

        // Boundaries: GRACE=0, PULSE_LEN=0 (treated as 1)
        wr(6'h1, 0);
        wr(6'h2, 0);
        expired_in = 1'b1;
        exp_at(1, K_UINT, "z_pend_int", 1);
        exp_at(1, K_SYS,  "z_pend_sys", 0);
        exp_at(2, K_SYS,  "z_rst_sys",  1);
        exp_at(2, K_UINT, "z_rst_int",  0);
        exp_at(3, K_SYS,  "z_hold_sys", 0);
        exp_at(3, K_UINT, "z_hold_int", 1);
        tick(3);
        expired_in = 1'b0;
        exp_at(1, K_UINT, "z_ack_int", 0);
        wr(6'h3, 0);
        // ACK on the cycle gcnt == 0
        expired_in = 1'b1;
        tick(1);
        exp_at(1, K_UINT, "z_ack0_int", 0);
        exp_at(1, K_SYS,  "z_ack0_sys", 0);
        exp_at(2, K_SYS,  "z_ack0_sys2", 0);
        wr(6'h3, 0);
        tick(1);
        expired_in = 1'b0;

        // auto_rearm: GRACE=1, PULSE_LEN=2
        wr(6'h0, 3);
        wr(6'h1, 1);
        wr(6'h2, 2);
        wr(6'h5, 0);
        expired_in = 1'b1;
        exp_at(1, K_UINT, "r_pend_int", 1);
        exp_at(2, K_UINT, "r_pend_int2", 1);
        exp_at(3, K_SYS,  "r_rst_sys", 1);
        exp_at(4, K_SYS,  "r_rst_sys2", 1);
        for (int k = 5; k <= 10; k++) begin
            exp_at(k, K_UINT, "r_level_int", 0);
            exp_at(k, K_SYS,  "r_level_sys", 0);
        end
        tick(11);
        expired_in = 1'b0;
        tick(2);
        expired_in = 1'b1;
        exp_at(1, K_UINT, "r_second_int", 1);
        tick(6);
        expired_in = 1'b0;
        rd(6'h5, 2, "r_events");
        rd(6'h4, 32'h0000_020C, "r_status");

        // Config lock and disable during RESET: GRACE=5, PULSE_LEN=6
        wr(6'h0, 1);
        wr(6'h1, 5);
        wr(6'h2, 6);
        expired_in = 1'b1;
        tick(2);
        wr(6'h1, 9);
        rd(6'h1, 5, "l_grace_locked");
        tick(4);
        exp_at(0, K_SYS, "d_rst_on", 1);
        exp_at(1, K_SYS, "d_rst_off", 0);
        exp_at(1, K_UO,  "d_uo", 32'h08);
        wr(6'h0, 0);
        rd(6'h4, 32'h0000_0310, "d_status");
        expired_in = 1'b0;
        rd(6'h1, 5, "l_grace_keep");

        // Reset mid-RESET: GRACE=0, PULSE_LEN=50
        wr(6'h0, 1);
        wr(6'h1, 0);
        wr(6'h2, 50);
        expired_in = 1'b1;
        tick(3);
        exp_at(0, K_SYS, "x_pre_sys", 1);
        rst        = 1'b1;
        expired_in = 1'b0;
        tick(1);
        exp_at(0, K_SYS,  "x_sys",  0);
        exp_at(0, K_UINT, "x_int",  0);
        exp_at(0, K_UO,   "x_uo",   0);
        exp_at(0, K_RDY,  "x_rdy",  1);
        rst = 1'b0;
        rd(6'h0, 0, "x_ctrl");
        rd(6'h1, 0, "x_grace");
        rd(6'h2, 0, "x_pulse");
        rd(6'h4, 0, "x_status");
        rd(6'h5, 0, "x_events");

        // Saturation: 300 short auto-rearmed escalations
        wr(6'h0, 3);
        wr(6'h2, 1);
        for (int n = 0; n < 300; n++) begin
            expired_in = 1'b1;
            tick(1);
            expired_in = 1'b0;
            tick(3);
        end
        rd(6'h5, 255, "s_events_sat");
        rd(6'h4, 32'h0000_FF0C, "s_status_sat");
        // EVENTS clear coincident with an increment
        expired_in = 1'b1;
        wr(6'h5, 0);
        expired_in = 1'b0;
        rd(6'h5, 0, "s_clear_wins");
        tick(4);
        // ACK and rising edge together in IDLE: edge is taken
        expired_in = 1'b1;
        exp_at(1, K_UINT, "s_ack_edge_int", 1);
        wr(6'h3, 0);
        expired_in = 1'b0;
        tick(5);
        done = 1'b1;
    end

    // Completion and cycle budget
    initial begin
        while (!done && cyc < 20000) @(posedge clk);
        if (!done) begin
            n_bad++;
            $display("FAIL timeout: driver not done after %0d cycles, want done", cyc);
        end
        @(negedge clk);
        #3;
        foreach (sb[i]) begin
            n_bad++;
            $display("FAIL %s: never checked (cycle %0d)", sb[i].nm, sb[i].cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
